// File: rtl/pc_next_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_ctrl
// Description : Producer side of the program-counter interface. Selects the
//               next fetch address and the hold/advance control sampled by the
//               PC register on every rising clk edge. Sequences the boot hold,
//               memory-wait stalls, fixed-length load-use stalls and redirects
//               that arrive while the PC is held (deferred redirects).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk             in   1  system clock, rising edge
//   rst_n           in   1  synchronous active-low reset
//   pc_cur          in  32  current PC register output
//   imem_ready      in   1  instruction memory accepts a fetch this cycle
//   load_use_hazard in   1  single-cycle load-use hazard pulse
//   branch_taken    in   1  resolved taken branch
//   branch_target   in  32  branch destination
//   jump            in   1  J/JAL resolved
//   jump_index      in  26  J-type instruction index field
//   jr              in   1  JR/JALR resolved
//   jr_target       in  32  register jump destination
//   exception       in   1  exception request
//   pc_next         out 32  PC register load value
//   pc_hold         out  1  1 = hold PC, 0 = load pc_next
//   flush_if        out  1  squash the fetch stage this cycle
//   redirect_cnt    out 16  saturating count of applied redirects
// ============================================================================
module pc_next_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_cur,
  input  logic        imem_ready,
  input  logic        load_use_hazard,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exception,
  output logic [31:0] pc_next,
  output logic        pc_hold,
  output logic        flush_if,
  output logic [15:0] redirect_cnt
);

  localparam logic [3:0] c_boot_last  = 4'(BOOT_CYCLES - 1);
  localparam logic [2:0] c_stall_load = 3'(STALL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_MEM = 2'd2,
    ST_HAZ      = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_boot_cnt;
  logic [3:0]  w_boot_cnt_nxt;
  logic [2:0]  r_stall_cnt;
  logic [2:0]  w_stall_cnt_nxt;
  logic        r_haz_pend;
  logic        w_haz_pend_nxt;
  logic        r_pend_valid;
  logic [31:0] r_pend_target;
  logic [15:0] r_redirect_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_jump_target;
  logic [31:0] w_new_target;
  logic [31:0] w_sel;
  logic        w_hold;
  logic        w_boot;
  logic        w_flush;

  // Address selection. w_new_target is the choice among this cycle's inputs
  // only; it is also what gets captured when a redirect must be deferred.
  always_comb begin
    w_pc_plus4    = pc_cur + 32'd4;
    w_jump_target = {w_pc_plus4[31:28], jump_index, 2'b00};
    w_new_target  = w_pc_plus4;
    if (exception)         w_new_target = EXC_VECTOR;
    else if (jr)           w_new_target = jr_target;
    else if (jump)         w_new_target = w_jump_target;
    else if (branch_taken) w_new_target = branch_target;
    // A pending redirect outranks everything except a fresh exception.
    if (exception)         w_sel = EXC_VECTOR;
    else if (r_pend_valid) w_sel = r_pend_target;
    else                   w_sel = w_new_target;
  end

  // Next-state and hold decision.
  always_comb begin
    w_state_nxt     = r_state;
    w_boot_cnt_nxt  = r_boot_cnt;
    w_stall_cnt_nxt = r_stall_cnt;
    w_haz_pend_nxt  = r_haz_pend;
    w_hold          = 1'b1;
    case (r_state)
      ST_BOOT: begin
        if (r_boot_cnt == c_boot_last) begin
          w_state_nxt    = ST_RUN;
          w_boot_cnt_nxt = 4'd0;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + 4'd1;
        end
      end
      // The cycle in which memory returns behaves exactly like a RUN cycle.
      ST_RUN, ST_WAIT_MEM: begin
        if (!imem_ready) begin
          w_state_nxt = ST_WAIT_MEM;
          // Memory wait wins, but the hazard is remembered for later.
          if (load_use_hazard) w_haz_pend_nxt = 1'b1;
        end else if (load_use_hazard || r_haz_pend) begin
          w_haz_pend_nxt  = 1'b0;
          w_stall_cnt_nxt = c_stall_load;
          w_state_nxt     = (STALL_CYCLES > 1) ? ST_HAZ : ST_RUN;
        end else begin
          w_hold      = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_HAZ: begin
        // The entering RUN cycle is the first stall cycle, so HAZ lasts
        // STALL_CYCLES-1 cycles and exits as the counter reaches zero.
        w_stall_cnt_nxt = r_stall_cnt - 3'd1;
        if (r_stall_cnt <= 3'd1) begin
          w_stall_cnt_nxt = 3'd0;
          w_state_nxt     = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  always_comb begin
    w_boot       = (r_state == ST_BOOT);
    w_flush      = rst_n & ~w_hold & (w_sel != w_pc_plus4);
    pc_hold      = ~rst_n | w_hold;
    pc_next      = (~rst_n | w_boot) ? RESET_VECTOR : w_sel;
    flush_if     = w_flush;
    redirect_cnt = r_redirect_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_boot_cnt     <= 4'd0;
      r_stall_cnt    <= 3'd0;
      r_haz_pend     <= 1'b0;
      r_pend_valid   <= 1'b0;
      r_pend_target  <= RESET_VECTOR;
      r_redirect_cnt <= 16'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_boot_cnt  <= w_boot_cnt_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      r_haz_pend  <= w_haz_pend_nxt;

      if (!w_boot) begin
        if (w_hold) begin
          // First redirect captured wins, except an exception always wins.
          if (exception) begin
            r_pend_target <= EXC_VECTOR;
            r_pend_valid  <= 1'b1;
          end else if (!r_pend_valid && (jr || jump || branch_taken)) begin
            r_pend_target <= w_new_target;
            r_pend_valid  <= 1'b1;
          end
        end else begin
          r_pend_valid <= 1'b0;
        end
      end

      if (w_flush && (r_redirect_cnt != 16'hFFFF)) begin
        r_redirect_cnt <= r_redirect_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_next_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_ctrl
// Description : Directed self-checking bench for pc_next_ctrl. Expected
//               outputs are queued when stimulus is applied and compared on
//               the falling edge of the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_cur;
  logic        imem_ready;
  logic        load_use_hazard;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic [31:0] pc_next;
  logic        pc_hold;
  logic        flush_if;
  logic [15:0] redirect_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    bit          chk_pc;
    logic        hold;
    logic        flush;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] c_EXC = 32'h8000_0180;

  pc_next_ctrl #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (c_EXC),
    .BOOT_CYCLES (2),
    .STALL_CYCLES(3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .imem_ready     (imem_ready),
    .load_use_hazard(load_use_hazard),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .jump           (jump),
    .jump_index     (jump_index),
    .jr             (jr),
    .jr_target      (jr_target),
    .exception      (exception),
    .pc_next        (pc_next),
    .pc_hold        (pc_hold),
    .flush_if       (flush_if),
    .redirect_cnt   (redirect_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue the expectation for the current cycle, then drain the scoreboard
  // against the DUT outputs on the falling edge.
  task automatic chk(input string tag, input logic [31:0] pc, input bit chk_pc,
                     input logic hold, input logic flush, input logic [15:0] cnt);
    exp_t e;
    e.tag = tag; e.pc = pc; e.chk_pc = chk_pc;
    e.hold = hold; e.flush = flush; e.cnt = cnt;
    sb.push_back(e);
    @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.chk_pc) begin
        checks++;
        assert (pc_next === e.pc) else begin
          failures++;
          $error("FAIL %s pc_next got=%h exp=%h", e.tag, pc_next, e.pc);
        end
      end
      checks++;
      assert (pc_hold === e.hold) else begin
        failures++;
        $error("FAIL %s pc_hold got=%b exp=%b", e.tag, pc_hold, e.hold);
      end
      checks++;
      assert (flush_if === e.flush) else begin
        failures++;
        $error("FAIL %s flush_if got=%b exp=%b", e.tag, flush_if, e.flush);
      end
      checks++;
      assert (redirect_cnt === e.cnt) else begin
        failures++;
        $error("FAIL %s redirect_cnt got=%h exp=%h", e.tag, redirect_cnt, e.cnt);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pc_cur = 32'h0; imem_ready = 1'b1; load_use_hazard = 1'b0;
    branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_index = 26'h0;
    jr = 1'b0; jr_target = 32'h0; exception = 1'b0;

    // Reset held for three edges, redirects present must be ignored.
    cyc();
    jr = 1'b1; jr_target = 32'h100;
    chk("reset", 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
    jr = 1'b0;
    cyc(); cyc();

    // Boot hold, redirect inputs ignored.
    rst_n = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h200;
    chk("boot0", 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
    cyc();
    branch_taken = 1'b0;
    chk("boot1", 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
    cyc();
    chk("run_first", 32'h4, 1'b1, 1'b0, 1'b0, 16'd0);
    cyc();

    // Sequential and wrap.
    pc_cur = 32'h0000_0040;
    chk("seq", 32'h44, 1'b1, 1'b0, 1'b0, 16'd0);
    cyc();
    pc_cur = 32'hFFFF_FFFC;
    chk("wrap", 32'h0, 1'b1, 1'b0, 1'b0, 16'd0);
    cyc();

    // Priority: jr over branch, then exception over all.
    pc_cur = 32'h40;
    jr = 1'b1; jr_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h200;
    chk("prio_jr", 32'h100, 1'b1, 1'b0, 1'b1, 16'd0);
    cyc();
    exception = 1'b1;
    chk("prio_exc", c_EXC, 1'b1, 1'b0, 1'b1, 16'd1);
    cyc();
    jr = 1'b0; branch_taken = 1'b0; exception = 1'b0;
    chk("post_prio", 32'h44, 1'b1, 1'b0, 1'b0, 16'd2);
    cyc();

    // Jump target keeps the upper nibble of pc+4.
    pc_cur = 32'h1000_0000; jump = 1'b1; jump_index = 26'h0000010;
    chk("jump", 32'h1000_0040, 1'b1, 1'b0, 1'b1, 16'd2);
    cyc();
    jump = 1'b0;

    // Deferred redirect across a memory wait; the first capture wins.
    pc_cur = 32'h500; imem_ready = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h300;
    chk("wait1", 32'h0, 1'b0, 1'b1, 1'b0, 16'd3);
    cyc();
    branch_taken = 1'b0; jr = 1'b1; jr_target = 32'h100;
    chk("wait2", 32'h0, 1'b0, 1'b1, 1'b0, 16'd3);
    cyc();
    jr = 1'b0;
    chk("wait3", 32'h0, 1'b0, 1'b1, 1'b0, 16'd3);
    cyc();
    imem_ready = 1'b1;
    chk("deferred_apply", 32'h300, 1'b1, 1'b0, 1'b1, 16'd3);
    cyc();
    pc_cur = 32'h300;
    chk("after_deferred", 32'h304, 1'b1, 1'b0, 1'b0, 16'd4);
    cyc();

    // Load-use hazard: three hold cycles.
    pc_cur = 32'h304; load_use_hazard = 1'b1;
    chk("haz1", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    load_use_hazard = 1'b0;
    chk("haz2", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    chk("haz3", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    chk("haz_done", 32'h308, 1'b1, 1'b0, 1'b0, 16'd4);
    cyc();

    // Exception with hazard: held, then exception applied from pending.
    load_use_hazard = 1'b1; exception = 1'b1;
    chk("exc_haz1", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    load_use_hazard = 1'b0; exception = 1'b0;
    chk("exc_haz2", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    chk("exc_haz3", 32'h0, 1'b0, 1'b1, 1'b0, 16'd4);
    cyc();
    chk("exc_apply", c_EXC, 1'b1, 1'b0, 1'b1, 16'd4);
    cyc();
    pc_cur = 32'h8000_0180;
    chk("after_exc", 32'h8000_0184, 1'b1, 1'b0, 1'b0, 16'd5);
    cyc();

    // Hazard with a captured branch, then reset in the second stall cycle.
    pc_cur = 32'h308; load_use_hazard = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h700;
    chk("haz_rst1", 32'h0, 1'b0, 1'b1, 1'b0, 16'd5);
    cyc();
    load_use_hazard = 1'b0; branch_taken = 1'b0; rst_n = 1'b0;
    chk("haz_rst2", 32'h0, 1'b1, 1'b1, 1'b0, 16'd5);
    cyc();
    rst_n = 1'b1;
    chk("reboot0", 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
    cyc();
    chk("reboot1", 32'h0, 1'b1, 1'b1, 1'b0, 16'd0);
    cyc();
    chk("reboot_run", 32'h30C, 1'b1, 1'b0, 1'b0, 16'd0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
